// File: rtl/multi_tick_divider.sv
// multi_tick_divider
// Multi-channel, runtime-programmable tick / clock-enable generator.
// Each channel divides clk by its own divisor and emits either a one-cycle
// pulse per period or a near-50% square enable. A new divisor is held in a
// shadow register and only becomes active at a period boundary, so the
// period in progress always completes with the old divisor. sync_clr
// restarts every channel together, which phase-aligns channels that share
// a divisor. The outputs are clock enables for downstream logic, never clocks.
module multi_tick_divider #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       mode,
   input  logic [NUM_CH*DIV_W-1:0] div_val,
   input  logic [NUM_CH-1:0]       div_load,
   input  logic                    sync_clr,
   output logic [NUM_CH-1:0]       tick_out,
   output logic [NUM_CH-1:0]       pend
);

   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] r_cnt;
      logic [DIV_W-1:0] r_act_div;
      logic [DIV_W-1:0] r_shadow;
      logic             r_pend;
      logic             r_tick;

      logic [DIV_W-1:0] w_slice;
      logic [DIV_W-1:0] w_n;
      logic [DIV_W-1:0] w_next_cnt;
      logic [DIV_W:0]   w_half;
      logic             w_wrap;
      logic             w_run;
      logic             w_apply;
      logic             w_tick_nxt;

      assign w_slice = div_val[gi*DIV_W +: DIV_W];

      // Derive the effective divisor, period end, next count and next tick level.
      // NOTE: every signal gets a default at the top of always_comb so no path
      // can leave it unassigned and infer a latch.
      always_comb begin
         w_n        = r_act_div;
         w_wrap     = 1'b0;
         w_next_cnt = '0;
         w_half     = '0;
         w_run      = en[gi] && !sync_clr;
         w_apply    = 1'b0;
         w_tick_nxt = 1'b0;

         // A divisor of zero is treated as one (tick every cycle).
         if (r_act_div == '0) begin
            w_n = DIV_W'(1);
         end
         w_wrap     = (r_cnt >= (w_n - DIV_W'(1)));
         w_next_cnt = w_wrap ? '0 : (r_cnt + DIV_W'(1));
         // ceil(N/2) needs one extra bit so N = 2^DIV_W-1 does not overflow.
         w_half     = ({1'b0, w_n} + (DIV_W+1)'(1)) >> 1;
         // Period boundary, idle, or global clear: safe moments to swap divisors.
         w_apply    = (w_run && w_wrap) || !en[gi] || sync_clr;

         if (mode[gi]) begin
            w_tick_nxt = ({1'b0, w_next_cnt} < w_half);
         end else begin
            w_tick_nxt = w_wrap;
         end
      end

      // Period counter and registered tick; idle or clear parks at count 0.
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values of the others.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
         end else if (!w_run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
         end else begin
            r_cnt  <= w_next_cnt;
            r_tick <= w_tick_nxt;
         end
      end

      // Shadowed divisor reload: capture on load, promote on the next apply event.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_act_div <= DEF_DIV;
            r_shadow  <= '0;
            r_pend    <= 1'b0;
         end else if (div_load[gi]) begin
            r_shadow <= w_slice;
            if (w_apply) begin
               // Load lands exactly on a boundary: take it now, nothing pending.
               r_act_div <= w_slice;
               r_pend    <= 1'b0;
            end else begin
               r_pend    <= 1'b1;
            end
         end else if (w_apply && r_pend) begin
            r_act_div <= r_shadow;
            r_pend    <= 1'b0;
         end
      end

      assign tick_out[gi] = r_tick;
      assign pend[gi]     = r_pend;
   end

endmodule

// File: doc/multi_tick_divider.md
Name: multi_tick_divider

Overview:
- Multi-channel, runtime-programmable clock-enable/tick generator; next generation of the fixed single-rate divider.
- Each channel divides clk by its own DIV_W-bit divisor and produces either a 1-cycle pulse or a near-50% square enable.
- Divisor reloads are glitch-free (shadowed, applied at period boundary). A global synchronous clear phase-aligns all channels.
- Sits between the system clock and the timing/flasher logic, which consumes the ticks as clock enables, never as clocks.

Parameters:
- NUM_CH, 2, number of independent channels (>=1)
- DIV_W, 8, divisor/counter width; max period 2^DIV_W-1
- DEFAULT_DIV, 4, active divisor of every channel after reset (1..2^DIV_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- mode  in  NUM_CH  per-channel output mode: 0 = pulse, 1 = square
- div_val  in  NUM_CH*DIV_W  new divisor; channel i uses bits [i*DIV_W +: DIV_W]
- div_load  in  NUM_CH  1-cycle strobe; captures div_val slice into channel shadow
- sync_clr  in  1  synchronous restart of all channels
- tick_out  out  NUM_CH  registered per-channel tick/enable output
- pend  out  NUM_CH  shadow divisor captured, not yet active

Behaviour:
- Reset (async): cnt=0, act_div=DEFAULT_DIV, shadow=0, pend=0, tick_out=0 for every channel.
- Effective divisor N = (act_div==0) ? 1 : act_div. Period is N clk cycles.
- Wrap = (cnt >= N-1). While en=1 and sync_clr=0, each edge sets cnt to 0 on wrap, else cnt+1 (DIV_W bits, no overflow possible).
- Pulse mode: tick_out <= wrap. First tick is high for exactly the one cycle after edge N following enable/clear. N=1 gives tick_out constantly 1.
- Square mode: tick_out <= (next_cnt < ceil(N/2)). High ceil(N/2) cycles, low floor(N/2) cycles. N=1 gives constant 1.
- mode change takes effect on the next edge; cnt is not disturbed.
- div_load=1: shadow <= slice, pend <= 1. A later load before apply overwrites the shadow (last wins).
- Apply event = wrap while running, OR en=0, OR sync_clr=1. On an apply event with pend=1: act_div <= shadow, pend <= 0.
- div_load coincident with an apply event: div_val slice goes straight to act_div, pend stays 0.
- The period in progress always completes with the old divisor; no runt or stretched pulses.
- en=0: cnt <= 0, tick_out <= 0. When en rises, counting starts from 0 (same timing as after reset).
- sync_clr=1 (priority over en): all channels cnt <= 0, tick_out <= 0, pending divisors applied. Channels with equal N are phase-aligned afterwards.
- Channels are fully independent apart from sync_clr.
- Reset mid-period discards the shadow and the count.

Test Plan:
- Reset, en=01, mode=0, DEFAULT_DIV=4 -> ch0 tick_out high 1 cycle at edges 4, 8, 12 after en; ch1 stays 0.
- ch0 mode=1, div=5 active -> pattern high 3 cycles, low 2 cycles, repeating; div=1 -> tick_out constant 1 in both modes; div=0 behaves as 1.
- ch0 running N=4: load 7 at cnt=1 -> pend=1; current period still ends at cnt=3; next periods are 7 cycles; pend clears on that wrap edge.
- Two loads (9 then 3) within one period -> 3 becomes active; load coincident with wrap -> new divisor active with no pend pulse.
- ch0 N=4, ch1 N=4 started 2 cycles apart, pulse sync_clr -> both tick_out low next cycle, then both tick together at edge 4 after clear.
- Assert rst mid-period with pend=1 -> all outputs 0 immediately; after release, divisor=DEFAULT_DIV and pend=0.
